// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung adder result checker: default widths,
// run-control state encoding and checker pipeline depth.
package bk_pkg;

    localparam int BK_WIDTH      = 32;
    localparam int BK_CNT_W      = 16;
    localparam int BK_PIPE_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bk_state_e;

endpackage

// File: rtl/bk_ref_adder.sv
// Golden WIDTH-bit adder with carry-in/carry-out, used as the reference
// against which the adder-under-test's response is compared.
module bk_ref_adder
    import bk_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/bk_result_checker.sv
// Response checker for a WIDTH-bit adder: three-stage compare pipeline, run FSM and
// saturating pass/error tallies. Define BK_CHK_CAPTURE_EN to latch the first failing vector.
module bk_result_checker
    import bk_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH,
    parameter int CNT_W = BK_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] pass_count,
    output logic             done
`ifdef BK_CHK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [WIDTH-1:0] fail_sum,
    output logic             fail_cout,
    output logic [CNT_W-1:0] fail_index
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    bk_state_e              state_r, state_next_s;
    logic [CNT_W-1:0]       acc_r, acc_next_s;
    logic [CNT_W-1:0]       n_r, n_next_s;
    logic                   in_ready_r, done_r, err_r;
    logic [CNT_W-1:0]       err_count_r, pass_count_r;
    logic                   start_taken_s, xfer_s, pipe_empty_s;
    logic [BK_PIPE_DEPTH-1:0] vld_r;

    logic [WIDTH-1:0]       s1_a_r, s1_b_r, s1_sum_r;
    logic                   s1_cin_r, s1_cout_r;
    logic [WIDTH-1:0]       ref_sum_s;
    logic                   ref_cout_s;
    logic                   s2_match_r, s3_match_r;

`ifdef BK_CHK_CAPTURE_EN
    logic [CNT_W-1:0]       s1_idx_r, s2_idx_r, s3_idx_r;
    logic [WIDTH-1:0]       s2_a_r, s2_b_r, s2_sum_r, s3_a_r, s3_b_r, s3_sum_r;
    logic                   s2_cin_r, s2_cout_r, s3_cin_r, s3_cout_r;
    logic [WIDTH-1:0]       fail_a_r, fail_b_r, fail_sum_r;
    logic                   fail_cin_r, fail_cout_r;
    logic [CNT_W-1:0]       fail_index_r;
`endif

    assign start_taken_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign xfer_s        = in_valid && in_ready_r;
    assign pipe_empty_s  = (vld_r == {BK_PIPE_DEPTH{1'b0}});

    bk_ref_adder #(.WIDTH(WIDTH)) u_ref (
        .a    (s1_a_r),
        .b    (s1_b_r),
        .cin  (s1_cin_r),
        .sum  (ref_sum_s),
        .cout (ref_cout_s)
    );

    // Run FSM next-state; an empty run skips straight to draining.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_taken_s) begin
                    state_next_s = (n_vectors == {CNT_W{1'b0}}) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                if (acc_r == n_r) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Next values of the accept counter and the sampled run length.
    always_comb begin
        n_next_s   = n_r;
        acc_next_s = acc_r;
        if (start_taken_s) begin
            n_next_s   = n_vectors;
            acc_next_s = {CNT_W{1'b0}};
        end else if (xfer_s) begin
            acc_next_s = acc_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control registers; in_ready and done are precomputed from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            acc_r      <= {CNT_W{1'b0}};
            n_r        <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            done_r     <= 1'b0;
            vld_r      <= {BK_PIPE_DEPTH{1'b0}};
        end else begin
            state_r    <= state_next_s;
            acc_r      <= acc_next_s;
            n_r        <= n_next_s;
            in_ready_r <= (state_next_s == ST_RUN) && (acc_next_s < n_next_s);
            done_r     <= (state_next_s == ST_DONE);
            vld_r      <= {vld_r[BK_PIPE_DEPTH-2:0], xfer_s};
        end
    end

    // Compare datapath: S1 capture, S2 golden compare, S3 result staging.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_sum_r   <= {WIDTH{1'b0}};
            s1_cin_r   <= 1'b0;
            s1_cout_r  <= 1'b0;
            s2_match_r <= 1'b0;
            s3_match_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                s1_a_r    <= a;
                s1_b_r    <= b;
                s1_sum_r  <= sum;
                s1_cin_r  <= cin;
                s1_cout_r <= cout;
            end
            s2_match_r <= ({ref_cout_s, ref_sum_s} == {s1_cout_r, s1_sum_r});
            s3_match_r <= s2_match_r;
        end
    end

`ifdef BK_CHK_CAPTURE_EN
    // Vector fields and index travel alongside the match bit for capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_idx_r  <= {CNT_W{1'b0}};
            s2_idx_r  <= {CNT_W{1'b0}};
            s3_idx_r  <= {CNT_W{1'b0}};
            s2_a_r    <= {WIDTH{1'b0}};
            s2_b_r    <= {WIDTH{1'b0}};
            s2_sum_r  <= {WIDTH{1'b0}};
            s3_a_r    <= {WIDTH{1'b0}};
            s3_b_r    <= {WIDTH{1'b0}};
            s3_sum_r  <= {WIDTH{1'b0}};
            s2_cin_r  <= 1'b0;
            s2_cout_r <= 1'b0;
            s3_cin_r  <= 1'b0;
            s3_cout_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                s1_idx_r <= acc_r;
            end
            s2_idx_r  <= s1_idx_r;
            s2_a_r    <= s1_a_r;
            s2_b_r    <= s1_b_r;
            s2_sum_r  <= s1_sum_r;
            s2_cin_r  <= s1_cin_r;
            s2_cout_r <= s1_cout_r;
            s3_idx_r  <= s2_idx_r;
            s3_a_r    <= s2_a_r;
            s3_b_r    <= s2_b_r;
            s3_sum_r  <= s2_sum_r;
            s3_cin_r  <= s2_cin_r;
            s3_cout_r <= s2_cout_r;
        end
    end
`endif

    // Tallies: cleared by an accepted start, updated as each result retires.
    always_ff @(posedge clk) begin
        if (rst || start_taken_s) begin
            err_r        <= 1'b0;
            err_count_r  <= {CNT_W{1'b0}};
            pass_count_r <= {CNT_W{1'b0}};
`ifdef BK_CHK_CAPTURE_EN
            fail_a_r     <= {WIDTH{1'b0}};
            fail_b_r     <= {WIDTH{1'b0}};
            fail_sum_r   <= {WIDTH{1'b0}};
            fail_cin_r   <= 1'b0;
            fail_cout_r  <= 1'b0;
            fail_index_r <= {CNT_W{1'b0}};
`endif
        end else if (vld_r[BK_PIPE_DEPTH-1]) begin
            if (s3_match_r) begin
                pass_count_r <= sat_inc(pass_count_r);
            end else begin
                err_count_r <= sat_inc(err_count_r);
                err_r       <= 1'b1;
`ifdef BK_CHK_CAPTURE_EN
                // err_r still low means this is the first mismatch of the run.
                if (!err_r) begin
                    fail_a_r     <= s3_a_r;
                    fail_b_r     <= s3_b_r;
                    fail_sum_r   <= s3_sum_r;
                    fail_cin_r   <= s3_cin_r;
                    fail_cout_r  <= s3_cout_r;
                    fail_index_r <= s3_idx_r;
                end
`endif
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign err        = err_r;
    assign err_count  = err_count_r;
    assign pass_count = pass_count_r;
    assign done       = done_r;
`ifdef BK_CHK_CAPTURE_EN
    assign fail_a     = fail_a_r;
    assign fail_b     = fail_b_r;
    assign fail_cin   = fail_cin_r;
    assign fail_sum   = fail_sum_r;
    assign fail_cout  = fail_cout_r;
    assign fail_index = fail_index_r;
`endif

endmodule

// File: tb/tb_bk_result_checker.sv
// Directed self-checking bench for bk_result_checker (BK_CHK_CAPTURE_EN adds capture checks).
module tb_bk_result_checker;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, cin, cout;
    logic [CNT_W-1:0] n_vectors;
    logic [WIDTH-1:0] a, b, sum;
    logic             in_ready, err, done;
    logic [CNT_W-1:0] err_count, pass_count;
`ifdef BK_CHK_CAPTURE_EN
    logic [WIDTH-1:0] fail_a, fail_b, fail_sum;
    logic             fail_cin, fail_cout;
    logic [CNT_W-1:0] fail_index;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bk_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_vectors  (n_vectors),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .sum        (sum),
        .cout       (cout),
        .err        (err),
        .err_count  (err_count),
        .pass_count (pass_count),
        .done       (done)
`ifdef BK_CHK_CAPTURE_EN
        ,
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_cin   (fail_cin),
        .fail_sum   (fail_sum),
        .fail_cout  (fail_cout),
        .fail_index (fail_index)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start     = 1'b1;
        n_vectors = n;
        tick();
        start     = 1'b0;
    endtask

    // Holds the vector until in_ready is seen; returns just after the transfer edge.
    task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                        input logic [WIDTH-1:0] vs, input logic vco);
        logic ok;
        ok       = 1'b0;
        a        = va;
        b        = vb;
        cin      = vc;
        sum      = vs;
        cout     = vco;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("send_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic send_good(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
        logic [WIDTH:0] r;
        r = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
        send(va, vb, vc, r[WIDTH-1:0], r[WIDTH]);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && !done; i++) tick();
        check("wait_done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; n_vectors = 16'd0;
        a = 32'd0; b = 32'd0; cin = 1'b0; sum = 32'd0; cout = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_err_count", {48'd0, err_count}, 64'd0);
        check("rst_pass_count", {48'd0, pass_count}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);

        // Four correct vectors.
        do_start(16'd4);
        check("t2_in_ready", {63'd0, in_ready}, 64'd1);
        send(32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b0);
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
        check("t2_ready_drop", {63'd0, in_ready}, 64'd0);
        wait_done();
        check("t2_pass", {48'd0, pass_count}, 64'd4);
        check("t2_err", {63'd0, err}, 64'd0);
        check("t2_err_count", {48'd0, err_count}, 64'd0);

        // Vector 2 wrong.
        do_start(16'd4);
        check("t3_done_clr", {63'd0, done}, 64'd0);
        check("t3_pass_clr", {48'd0, pass_count}, 64'd0);
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0);
        send(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b1);
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b0);
        send(32'h0000_0007, 32'h0000_0009, 1'b1, 32'h0000_0011, 1'b0);
        wait_done();
        check("t3_err", {63'd0, err}, 64'd1);
        check("t3_err_count", {48'd0, err_count}, 64'd1);
        check("t3_pass", {48'd0, pass_count}, 64'd3);
`ifdef BK_CHK_CAPTURE_EN
        check("t3_fail_index", {48'd0, fail_index}, 64'd2);
        check("t3_fail_sum", {32'd0, fail_sum}, 64'd0);
        check("t3_fail_a", {32'd0, fail_a}, 64'd5);
        check("t3_fail_b", {32'd0, fail_b}, 64'd3);
`endif

        // Wrap-around: correct carry-out passes, missing carry-out fails.
        do_start(16'd2);
        check("t4_err_clr", {63'd0, err}, 64'd0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
        wait_done();
        check("t4_pass", {48'd0, pass_count}, 64'd1);
        check("t4_err", {63'd0, err}, 64'd1);
        check("t4_err_count", {48'd0, err_count}, 64'd1);
`ifdef BK_CHK_CAPTURE_EN
        check("t4_fail_index", {48'd0, fail_index}, 64'd1);
        check("t4_fail_cout", {63'd0, fail_cout}, 64'd0);
        check("t4_fail_cin", {63'd0, fail_cin}, 64'd1);
`endif

        // Latency of a single failing vector.
        do_start(16'd1);
        send(32'h0000_0007, 32'h0000_0008, 1'b0, 32'h0000_0010, 1'b0);
        tick();
        tick();
        check("lat_err_n2", {63'd0, err}, 64'd0);
        tick();
        check("lat_err_n3", {63'd0, err}, 64'd1);
        check("lat_errc_n3", {48'd0, err_count}, 64'd1);
        check("lat_done_n3", {63'd0, done}, 64'd0);
        tick();
        check("lat_done_n4", {63'd0, done}, 64'd1);

        // 16 vectors with random bubbles.
        do_start(16'd16);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_good($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        check("t5_ready_drop", {63'd0, in_ready}, 64'd0);
        tick();
        tick();
        tick();
        check("t5_done_n3", {63'd0, done}, 64'd0);
        check("t5_pass_n3", {48'd0, pass_count}, 64'd16);
        tick();
        check("t5_done_n4", {63'd0, done}, 64'd1);
        a = 32'd1; b = 32'd1; cin = 1'b0; sum = 32'd9; cout = 1'b0;
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("t5_no_extra_pass", {48'd0, pass_count}, 64'd16);
        check("t5_no_extra_err", {63'd0, err}, 64'd0);
        check("t5_no_extra_errc", {48'd0, err_count}, 64'd0);

        // Empty run, then a start ignored mid-run.
        do_start(16'd0);
        check("t6_in_ready", {63'd0, in_ready}, 64'd0);
        check("t6_done_early", {63'd0, done}, 64'd0);
        tick();
        check("t6_done", {63'd0, done}, 64'd1);
        check("t6_pass", {48'd0, pass_count}, 64'd0);
        do_start(16'd3);
        send_good(32'h0000_0100, 32'h0000_0200, 1'b0);
        start = 1'b1;
        n_vectors = 16'd5;
        tick();
        start = 1'b0;
        send_good(32'h0000_0300, 32'h0000_0400, 1'b1);
        send_good(32'hDEAD_BEEF, 32'h1000_0000, 1'b0);
        wait_done();
        check("t6_ign_pass", {48'd0, pass_count}, 64'd3);

        // Reset mid-run with err set and a failing vector still in flight.
        do_start(16'd4);
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b0);
        repeat (3) tick();
        check("t1_err_pre", {63'd0, err}, 64'd1);
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("t1_err", {63'd0, err}, 64'd0);
        check("t1_err_count", {48'd0, err_count}, 64'd0);
        check("t1_in_ready", {63'd0, in_ready}, 64'd0);
        check("t1_done", {63'd0, done}, 64'd0);
        repeat (4) tick();
        check("t1_err_late", {63'd0, err}, 64'd0);
        check("t1_errc_late", {48'd0, err_count}, 64'd0);
        check("t1_pass_late", {48'd0, pass_count}, 64'd0);
        check("t1_ready_late", {63'd0, in_ready}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
